// File: rtl/round_robin_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant.
// Define ARB_TIMEOUT_EN to build the HOLD_MAX grant timeout.
module round_robin_arbiter4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] ptr;
    logic [1:0] ptr_n;
    logic [1:0] id_n;
    logic [3:0] gnt_n;
    logic       new_grant;
    logic       rel;
    logic       timeout;

    if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_bad_hold
        $error("HOLD_MAX out of range 2..255");
    end

    function automatic logic [3:0] dec(input logic [1:0] id);
        logic [3:0] d;
        d = 4'b0000;
        d[id] = 1'b1;
        return d;
    endfunction

    // First set bit in the order p, p+1, p+2, p+3 (mod 4)
    function automatic logic [1:0] pick(
        input logic [3:0] r,
        input logic [1:0] p
    );
        logic [7:0] dbl;
        logic [3:0] rot;
        dbl = {r, r} >> p;
        rot = dbl[3:0];
        if (rot[0])
            return p;
        else if (rot[1])
            return p + 2'd1;
        else if (rot[2])
            return p + 2'd2;
        else
            return p + 2'd3;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_n;

    assign timeout = (hold_cnt == HOLD_LAST)
                   && |(req & ~dec(gnt_id));

    always_comb begin
        hold_cnt_n = hold_cnt;
        if (state_n == GRANT) begin
            if (new_grant)
                hold_cnt_n = 8'd0;
            else if (hold_cnt != HOLD_LAST)
                hold_cnt_n = hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= 8'd0;
        else
            hold_cnt <= hold_cnt_n;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        id_n      = gnt_id;
        new_grant = 1'b0;
        rel       = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && (|req)) begin
                    state_n   = GRANT;
                    id_n      = pick(req, ptr);
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                rel = !en || !req[gnt_id] || timeout;
                if (rel) begin
                    // Next search starts just past the releasing owner
                    ptr_n = gnt_id + 2'd1;
                    if (en && (|req)) begin
                        id_n      = pick(req, gnt_id + 2'd1);
                        new_grant = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        gnt_n = (state_n == GRANT) ? dec(id_n) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            gnt_id <= 2'd0;
            gnt    <= 4'b0000;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gnt_id <= id_n;
            gnt    <= gnt_n;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_round_robin_arbiter4.sv
// Scoreboard bench for round_robin_arbiter4 against a
// behavioural owner/pointer model.
module tb_round_robin_arbiter4;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;

    round_robin_arbiter4 #(.HOLD_MAX(HM)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        int         n;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   total = 0;
    int   bad = 0;
    int   step_no = 0;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    // Model state: owner index or -1, last owner, pointer, hold age
    int m_owner, m_last, m_ptr, m_hold;

    function automatic int pick_m(int r, int p);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (p + i) % 4;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic void m_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_hold  = 0;
    endfunction

    function automatic void m_step(int e, int r);
        if (m_owner < 0) begin
            if (e != 0 && r != 0) begin
                m_owner = pick_m(r, m_ptr);
                m_last  = m_owner;
                m_hold  = 0;
            end
        end else begin
            int others;
            bit go;
            others = r & ~(1 << m_owner);
            go = (e == 0) || (r[m_owner] == 1'b0)
               || (TO && m_hold == HM - 1 && others != 0);
            if (go) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                if (e != 0 && r != 0) begin
                    m_owner = pick_m(r, m_ptr);
                    m_last  = m_owner;
                    m_hold  = 0;
                end
            end else if (m_hold < HM - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t x;
        x.g  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        x.id = 2'(m_last);
        x.b  = (m_owner >= 0);
        x.n  = step_no;
        step_no++;
        q.push_back(x);
    endfunction

    task automatic cyc(input logic e, input logic [3:0] r);
        @(negedge clk);
        en  = e;
        req = r;
        m_step(int'(e), int'(r));
        push_exp();
    endtask

    // Reset between edges; checked before the next rising edge
    task automatic rst_mid();
        @(negedge clk);
        #2;
        rst = 1'b1;
        m_reset();
        push_exp();
        ->chk_ev;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (gnt !== e.g || gnt_id !== e.id || busy !== e.b) begin
                    bad++;
                    $display("FAIL step%0d: got gnt=%b id=%0d busy=%b want gnt=%b id=%0d busy=%b",
                             e.n, gnt, gnt_id, busy, e.g, e.id, e.b);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] r;
        logic       e;
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        m_reset();
        repeat (2) @(negedge clk);
        push_exp();
        ->chk_ev;
        @(posedge clk);
        #2;
        rst = 1'b0;

        // first grant from ptr 0, hand-over, drain
        cyc(1'b1, 4'b1010);
        cyc(1'b1, 4'b1000);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);

        // rotation with one-cycle drops
        rst_mid();
        cyc(1'b1, 4'b1111);
        cyc(1'b1, 4'b1111);
        cyc(1'b1, 4'b1110);
        cyc(1'b1, 4'b1111);
        cyc(1'b1, 4'b1101);
        cyc(1'b1, 4'b1111);
        cyc(1'b1, 4'b1011);
        cyc(1'b1, 4'b1111);
        cyc(1'b1, 4'b0111);
        cyc(1'b1, 4'b1111);

        // enable drop while owner 2, then wrap search
        rst_mid();
        cyc(1'b1, 4'b0100);
        cyc(1'b1, 4'b0100);
        cyc(1'b0, 4'b0100);
        cyc(1'b0, 4'b1111);
        cyc(1'b1, 4'b0101);

        // reset mid-grant, then first grant from ptr 0
        rst_mid();
        cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b0001);
        rst_mid();
        cyc(1'b1, 4'b1111);
        cyc(1'b1, 4'b0000);

        // long holds: two contenders, then sole requester
        rst_mid();
        repeat (20) cyc(1'b1, 4'b0011);
        repeat (12) cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b1001);
        repeat (6) cyc(1'b1, 4'b1001);

        // random traffic with persistent requests
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                r = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 11) != 0);
            cyc(e, r);
            if ($urandom_range(0, 400) == 0)
                rst_mid();
        end

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
